// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC controller and its wrapper.
package cordic_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Width of a counter that must be able to hold the value `iterations`.
  function automatic int cnt_w(input int iterations);
    return $clog2(iterations + 1);
  endfunction

endpackage

// File: rtl/cordic_ctrl.sv
// Control path for one CORDIC rotation per request.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE and the result stays frozen until out_ready is seen with it.
//
// Sequence: IDLE (accept, latch target) -> LOAD (one dp_load pulse) ->
// RUN (one add/sub+iter per cycle until budget spent or dp_reached) ->
// CAPTURE (latch datapath x/y, count, early flag) -> DONE -> IDLE.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH       = 16,
  parameter int LOG_2_BIT_WIDTH = 4,
  parameter int ITERATIONS      = BIT_WIDTH - 1,
  parameter int CNT_W           = cnt_w(ITERATIONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  // request side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_target,
  // result side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_x,
  output logic [BIT_WIDTH-1:0] out_y,
  output logic [CNT_W-1:0]     out_iters,
  output logic                 out_early,
  // datapath controls
  output logic                 dp_add,
  output logic                 dp_sub,
  output logic                 dp_iter,
  output logic                 dp_load,
  output logic [BIT_WIDTH-1:0] dp_target,
  // datapath status
  input  logic                 dp_reached,
  input  logic                 dp_dir,
  input  logic [BIT_WIDTH-1:0] dp_x,
  input  logic [BIT_WIDTH-1:0] dp_y
);

  // The iteration budget must keep the datapath shift index in range, and
  // the shift index must be wide enough to address every bit position.
  if (ITERATIONS < 1 || ITERATIONS > BIT_WIDTH - 1 ||
      (1 << LOG_2_BIT_WIDTH) < BIT_WIDTH) begin : g_bad_params
    $error("cordic_ctrl: ITERATIONS must be 1..BIT_WIDTH-1 and LOG_2_BIT_WIDTH must cover BIT_WIDTH");
  end

  localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(ITERATIONS);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_early;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [BIT_WIDTH-1:0]  r_out_x;
  logic [BIT_WIDTH-1:0]  r_out_y;
  logic [CNT_W-1:0]      r_out_iters;
  logic                  r_out_early;
  logic [BIT_WIDTH-1:0]  r_dp_target;

  logic                  w_run;
  logic                  w_step;
  logic [CNT_W-1:0]      w_cnt_inc;

  // A RUN cycle performs a rotate step unless the datapath already hit target.
  assign w_run  = (r_state == RUN);
  assign w_step = w_run && !dp_reached;

  // Saturating increment: the counter stops at ITERATIONS and never wraps.
  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt != ITER_MAX) begin
      w_cnt_inc = r_cnt + 1'b1;
    end
  end

  // Datapath controls decoded from state and status; all zero outside LOAD/RUN.
  always_comb begin
    dp_add  = 1'b0;
    dp_sub  = 1'b0;
    dp_iter = 1'b0;
    dp_load = (r_state == LOAD);
    if (w_step) begin
      dp_add  = dp_dir;
      dp_sub  = !dp_dir;
      dp_iter = 1'b1;
    end
  end

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_early     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_iters <= '0;
      r_out_early <= 1'b0;
      r_dp_target <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Only here may the target change: the datapath compares against
            // it continuously for the whole run.
            r_dp_target <= in_target;
            r_cnt       <= '0;
            r_early     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_state <= RUN;
        end
        RUN: begin
          if (dp_reached) begin
            r_early <= 1'b1;
            r_state <= CAPTURE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == ITER_MAX) begin
              r_state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          r_out_x     <= dp_x;
          r_out_y     <= dp_y;
          r_out_iters <= r_cnt;
          r_out_early <= r_early;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_iters = r_out_iters;
  assign out_early = r_out_early;
  assign dp_target = r_dp_target;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl: a stand-in datapath follows the controls, and a
// reference model predicts each result from the request target, the planned
// number of steps before the target is "reached", and the chosen directions.
module tb_cordic_ctrl;

  localparam int BW   = 16;
  localparam int ITER = 15;
  localparam int CW   = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_x, out_y;
  logic [CW-1:0] out_iters;
  logic          out_early;
  logic          dp_add, dp_sub, dp_iter, dp_load;
  logic [BW-1:0] dp_target;
  logic          dp_reached, dp_dir;
  logic [BW-1:0] dp_x, dp_y;

  cordic_ctrl #(
    .BIT_WIDTH(BW), .LOG_2_BIT_WIDTH(4), .ITERATIONS(ITER), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_iters(out_iters), .out_early(out_early),
    .dp_add(dp_add), .dp_sub(dp_sub), .dp_iter(dp_iter), .dp_load(dp_load),
    .dp_target(dp_target),
    .dp_reached(dp_reached), .dp_dir(dp_dir), .dp_x(dp_x), .dp_y(dp_y)
  );

  // ---------------- stand-in datapath ----------------
  // x starts at the target and moves by +/-(step+1) per add/sub; y grows by
  // 0x0101 per iter. "Reached" fires once planned_k steps have been taken.
  int            planned_k = 100;
  logic          dirs [16];
  logic [BW-1:0] dpm_x = '0;
  logic [BW-1:0] dpm_y = '0;
  int            dpm_steps = 0;

  always @(posedge clk) begin
    if (dp_load) begin
      dpm_x     <= dp_target;
      dpm_y     <= '0;
      dpm_steps <= 0;
    end else if (dp_iter) begin
      if (dp_add)      dpm_x <= dpm_x + 16'(dpm_steps + 1);
      else if (dp_sub) dpm_x <= dpm_x - 16'(dpm_steps + 1);
      dpm_y     <= dpm_y + 16'h0101;
      dpm_steps <= dpm_steps + 1;
    end
  end

  assign dp_x       = dpm_x;
  assign dp_y       = dpm_y;
  assign dp_reached = (dpm_steps == planned_k);
  assign dp_dir     = (dpm_steps < 16) ? dirs[dpm_steps] : 1'b0;

  // ---------------- scoreboard ----------------
  int               n_cmp = 0;
  int               n_err = 0;
  logic [36:0]      exp_q [$];
  logic [BW-1:0]    cur_tgt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {x, y, iters, early} for one request.
  function automatic logic [36:0] ref_result(input logic [BW-1:0] tgt, input int k);
    int            iters;
    logic          early;
    logic [BW-1:0] x;
    iters = (k < ITER) ? k : ITER;
    early = (k < ITER);
    x     = tgt;
    for (int i = 0; i < iters; i++) begin
      x = dirs[i] ? x + 16'(i + 1) : x - 16'(i + 1);
    end
    return {x, 16'(iters * 16'h0101), 4'(iters), early};
  endfunction

  // Per-cycle control rules.
  always @(negedge clk) begin
    if (!reset) begin
      chk("add_sub_excl", 32'(dp_add & dp_sub), 0);
      chk("iter_pairing", 32'(dp_iter), 32'(dp_add | dp_sub));
      chk("load_alone", 32'(dp_load & (dp_add | dp_sub | dp_iter)), 0);
      if (dp_iter) chk("dir_follow", 32'(dp_add), 32'(dp_dir));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic plan(input logic [BW-1:0] tgt, input int k);
    planned_k = k;
    for (int i = 0; i < 16; i++) dirs[i] = 1'($urandom_range(0, 1));
    exp_q.push_back(ref_result(tgt, k));
    cur_tgt = tgt;
  endtask

  // Present a request and return #1 after the accept edge.
  task automatic start(input logic [BW-1:0] tgt, input int k);
    int guard;
    plan(tgt, k);
    @(negedge clk);
    in_valid  = 1'b1;
    in_target = tgt;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", 32'(guard < 50), 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_target = 16'($urandom);
  endtask

  // From just after the accept edge, count cycles until out_valid.
  task automatic wait_out(input int k, input logic [BW-1:0] tgt);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      chk("busy_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(1 + n), (k < ITER) ? 32'(4 + k) : 32'(3 + ITER));
    chk("dp_target_run", 32'(dp_target), 32'(tgt));
  endtask

  // Check the held result, optionally stall it, then complete the handshake.
  task automatic take(input int hold);
    logic [36:0] e;
    chk("queue_nonempty", 32'(exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("out_valid", 32'(out_valid), 1);
    chk("out_x", 32'(out_x), 32'(e[36:21]));
    chk("out_y", 32'(out_y), 32'(e[20:5]));
    chk("out_iters", 32'(out_iters), 32'(e[4:1]));
    chk("out_early", 32'(out_early), 32'(e[0]));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_target = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_x", 32'(out_x), 32'(e[36:21]));
      chk("bp_y", 32'(out_y), 32'(e[20:5]));
      chk("bp_iters", 32'(out_iters), 32'(e[4:1]));
      chk("bp_early", 32'(out_early), 32'(e[0]));
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_dp_target", 32'(dp_target), 32'(cur_tgt));
      chk("bp_dp_ctrl", 32'({dp_add, dp_sub, dp_iter, dp_load}), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 32'(out_valid), 0);
    chk("post_hs_ready", 32'(in_ready), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [BW-1:0] t;
    int            k;

    // Reset for two cycles, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_xy", 32'({out_x, out_y}), 0);
    chk("rst_out_misc", 32'({out_iters, out_early}), 0);
    chk("rst_dp_target", 32'(dp_target), 0);
    chk("rst_dp_ctrl", 32'({dp_add, dp_sub, dp_iter, dp_load}), 0);

    // Target reached immediately: no steps, early exit.
    start(16'h0000, 0);
    chk("load_pulse", 32'(dp_load), 1);
    wait_out(0, 16'h0000);
    take(0);

    // Full run with backpressure on the result.
    start(16'h1234, 20);
    wait_out(20, 16'h1234);
    take(10);

    // Budget boundary: one step short of the budget, and exactly the budget.
    start(16'h7f00, 14);
    wait_out(14, 16'h7f00);
    take(1);
    start(16'h8001, 15);
    wait_out(15, 16'h8001);
    take(2);

    // Randomized requests.
    for (int r = 0; r < 8; r++) begin
      t = 16'($urandom);
      k = $urandom_range(0, 18);
      start(t, k);
      wait_out(k, t);
      take($urandom_range(0, 3));
    end

    // Reset in the middle of RUN step 5.
    start(16'h4321, 20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("step5_iter", 32'(dp_iter), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_dp_ctrl", 32'({dp_add, dp_sub, dp_iter, dp_load}), 0);
    chk("midrst_dp_target", 32'(dp_target), 0);
    reset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());

    start(16'h0800, 20);
    wait_out(20, 16'h0800);
    take(0);

    // Back-to-back with in_valid and out_ready held high.
    plan(16'h1111, 3);
    exp_q.push_back(ref_result(16'h2222, 3));
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_target = 16'h1111;
    chk("b2b_ready", 32'(in_ready), 1);
    @(posedge clk);
    wait_out(3, 16'h1111);
    in_target = 16'h2222;
    begin
      logic [36:0] e1;
      e1 = exp_q.pop_front();
      chk("b2b_x1", 32'(out_x), 32'(e1[36:21]));
      chk("b2b_iters1", 32'(out_iters), 32'(e1[4:1]));
      chk("b2b_early1", 32'(out_early), 32'(e1[0]));
    end
    @(posedge clk);
    #1;
    chk("b2b_idle_no_load", 32'(dp_load), 0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(in_ready), 1);
    chk("b2b_idle_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cur_tgt   = 16'h2222;
    chk("b2b_second_load", 32'(dp_load), 1);
    chk("b2b_second_target", 32'(dp_target), 32'h2222);
    wait_out(3, 16'h2222);
    take(1);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
